// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI Mode 1 strobed-I/O handshake.
package ppi_pkg;

    localparam int unsigned PPI_WIDTH = 8;

    // Port C status bit positions in Mode 1 (group A then group B)
    localparam int unsigned PC_INTR_A  = 3;
    localparam int unsigned PC_IBF_A   = 5;
    localparam int unsigned PC_OBF_N_A = 7;
    localparam int unsigned PC_INTE_A_IN  = 4;
    localparam int unsigned PC_INTE_A_OUT = 6;
    localparam int unsigned PC_INTR_B  = 0;
    localparam int unsigned PC_IBF_B   = 1;
    localparam int unsigned PC_OBF_N_B = 1;
    localparam int unsigned PC_INTE_B  = 2;

    typedef enum logic [2:0] {
        DISABLED  = 3'd0,
        IN_EMPTY  = 3'd1,
        IN_FULL   = 3'd2,
        OUT_EMPTY = 3'd3,
        OUT_FULL  = 3'd4
    } hs_state_t;

    function automatic hs_state_t empty_state(input logic mode1_en, input logic dir_in);
        hs_state_t st;
        if (!mode1_en) begin
            st = DISABLED;
        end else if (dir_in) begin
            st = IN_EMPTY;
        end else begin
            st = OUT_EMPTY;
        end
        return st;
    endfunction

    // True when the current state belongs to the configured port direction
    function automatic logic cfg_matches(input hs_state_t st, input logic mode1_en,
                                         input logic dir_in);
        logic ok;
        case (st)
            DISABLED:            ok = ~mode1_en;
            IN_EMPTY, IN_FULL:   ok = mode1_en & dir_in;
            OUT_EMPTY, OUT_FULL: ok = mode1_en & ~dir_in;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ppi_edge_sync.sv
// Peripheral strobe synchronizer with rise/fall pulse outputs.
// PPI_STB_SYNC_EN selects a two-flop synchronizer instead of a single sampling flop.
module ppi_edge_sync
    import ppi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_s,
    output logic fall_s
);

    logic level_s;
    logic prev_r;

`ifdef PPI_STB_SYNC_EN
    logic meta_r;
    logic sync_r;

    // Two-flop synchronizer; idle level of the strobes is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end
    assign level_s = sync_r;
`else
    logic samp_r;

    // Single sampling flop for peripherals already synchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_r <= 1'b1;
        end else begin
            samp_r <= async_in;
        end
    end
    assign level_s = samp_r;
`endif

    // Edge history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= level_s;
        end
    end

    assign rise_s = level_s & ~prev_r;
    assign fall_s = ~level_s & prev_r;

endmodule

// File: rtl/ppi_mode1_handshake.sv
// Mode 1 strobed-I/O handshake controller for one PPI port.
// Build option: PPI_STB_SYNC_EN (two-flop synchronizer on STB_N/ACK_N).
module ppi_mode1_handshake
    import ppi_pkg::*;
#(
    parameter int unsigned WIDTH = PPI_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             MODE1_EN,
    input  logic             DIR_IN,
    input  logic             SEL,
    input  logic             READ,
    input  logic             WRITE,
    input  logic [WIDTH-1:0] DATA_W,
    input  logic [WIDTH-1:0] PORT_PINS,
    input  logic             STB_N,
    input  logic             ACK_N,
    input  logic             INTE_SET,
    input  logic             INTE_CLR,
    output logic [WIDTH-1:0] DATA_R,
    output logic [WIDTH-1:0] PORT_OUT,
    output logic             PORT_OE,
    output logic             IBF,
    output logic             OBF_N,
    output logic             INTR,
    output logic             OVR,
    output logic             INTE
);

    hs_state_t        state_r;
    logic [WIDTH-1:0] data_r_r;
    logic [WIDTH-1:0] port_out_r;
    logic             port_oe_r;
    logic             ibf_r;
    logic             obf_n_r;
    logic             intr_r;
    logic             intr_req_r;
    logic             ovr_r;
    logic             inte_r;
    logic             rd_prev_r;
    logic             wr_prev_r;

    logic rd_s, wr_s;
    logic rd_assert_s, rd_deassert_s, wr_assert_s, wr_deassert_s;
    logic stb_rise_s, stb_fall_s, ack_rise_s, ack_fall_s;
    logic srst_s;
    logic intr_req_nxt_s;
    logic inte_nxt_s;

    ppi_edge_sync u_stb_sync (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .async_in (STB_N),
        .rise_s   (stb_rise_s),
        .fall_s   (stb_fall_s)
    );

    ppi_edge_sync u_ack_sync (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .async_in (ACK_N),
        .rise_s   (ack_rise_s),
        .fall_s   (ack_fall_s)
    );

    assign rd_s          = READ & SEL;
    assign wr_s          = WRITE & SEL;
    assign rd_assert_s   = rd_s & ~rd_prev_r;
    assign rd_deassert_s = ~rd_s & rd_prev_r;
    assign wr_assert_s   = wr_s & ~wr_prev_r;
    assign wr_deassert_s = ~wr_s & wr_prev_r;

    // A configuration change restarts the handshake from the empty state
    assign srst_s = ~cfg_matches(state_r, MODE1_EN, DIR_IN);

    // Interrupt enable next value; clear dominates set
    always_comb begin
        inte_nxt_s = inte_r;
        if (INTE_CLR) begin
            inte_nxt_s = 1'b0;
        end else if (INTE_SET) begin
            inte_nxt_s = 1'b1;
        end else begin
            inte_nxt_s = inte_r;
        end
    end

    // Interrupt request next value; CPU edges are checked first so they win
    always_comb begin
        intr_req_nxt_s = intr_req_r;
        case (state_r)
            IN_FULL: begin
                if (rd_assert_s) begin
                    intr_req_nxt_s = 1'b0;
                end else if (stb_rise_s) begin
                    intr_req_nxt_s = 1'b1;
                end else begin
                    intr_req_nxt_s = intr_req_r;
                end
            end
            OUT_EMPTY: begin
                if (wr_assert_s) begin
                    intr_req_nxt_s = 1'b0;
                end else begin
                    intr_req_nxt_s = intr_req_r;
                end
            end
            OUT_FULL: begin
                if (wr_assert_s) begin
                    intr_req_nxt_s = 1'b0;
                end else if (obf_n_r && ack_rise_s) begin
                    intr_req_nxt_s = 1'b1;
                end else begin
                    intr_req_nxt_s = intr_req_r;
                end
            end
            default: intr_req_nxt_s = intr_req_r;
        endcase
    end

    // CPU strobe history, interrupt enable and pin-drive enable
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_prev_r <= 1'b0;
            wr_prev_r <= 1'b0;
            inte_r    <= 1'b0;
            port_oe_r <= 1'b0;
        end else begin
            rd_prev_r <= rd_s;
            wr_prev_r <= wr_s;
            inte_r    <= inte_nxt_s;
            port_oe_r <= MODE1_EN & ~DIR_IN;
        end
    end

    // Handshake FSM with latches and status flags; CPU actions are applied last
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= DISABLED;
            data_r_r   <= '0;
            port_out_r <= '0;
            ibf_r      <= 1'b0;
            obf_n_r    <= 1'b1;
            intr_req_r <= 1'b0;
            intr_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else if (srst_s) begin
            state_r    <= empty_state(MODE1_EN, DIR_IN);
            ibf_r      <= 1'b0;
            obf_n_r    <= 1'b1;
            intr_req_r <= 1'b0;
            intr_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            intr_req_r <= intr_req_nxt_s;
            intr_r     <= intr_req_nxt_s & inte_nxt_s;
            case (state_r)
                IN_EMPTY: begin
                    if (stb_fall_s) begin
                        data_r_r <= PORT_PINS;
                        ibf_r    <= 1'b1;
                        state_r  <= IN_FULL;
                    end
                end
                IN_FULL: begin
                    if (stb_fall_s) begin
                        ovr_r <= 1'b1;
                    end
                    if (rd_deassert_s) begin
                        ibf_r   <= 1'b0;
                        ovr_r   <= 1'b0;
                        state_r <= IN_EMPTY;
                    end
                end
                OUT_EMPTY, OUT_FULL: begin
                    if (wr_assert_s) begin
                        port_out_r <= DATA_W;
                    end
                    // obf_n_r high inside OUT_FULL marks that the ACK_N fall was seen
                    if ((state_r == OUT_FULL) && !obf_n_r && ack_fall_s) begin
                        obf_n_r <= 1'b1;
                    end
                    if ((state_r == OUT_FULL) && obf_n_r && ack_rise_s) begin
                        state_r <= OUT_EMPTY;
                    end
                    if (wr_deassert_s) begin
                        obf_n_r <= 1'b0;
                        state_r <= OUT_FULL;
                    end
                end
                default: state_r <= state_r;
            endcase
        end
    end

    assign DATA_R   = data_r_r;
    assign PORT_OUT = port_out_r;
    assign PORT_OE  = port_oe_r;
    assign IBF      = ibf_r;
    assign OBF_N    = obf_n_r;
    assign INTR     = intr_r;
    assign OVR      = ovr_r;
    assign INTE     = inte_r;

endmodule

// File: tb/tb_ppi_mode1_handshake.sv
// Directed self-checking bench for ppi_mode1_handshake (either PPI_STB_SYNC_EN build).
module tb_ppi_mode1_handshake;

`ifdef PPI_STB_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk_s = 1'b0;
    logic       rst_n_s, mode1_en_s, dir_in_s, sel_s, read_s, write_s;
    logic [7:0] data_w_s, port_pins_s;
    logic       stb_n_s, ack_n_s, inte_set_s, inte_clr_s;
    logic [7:0] data_r_s, port_out_s;
    logic       port_oe_s, ibf_s, obf_n_s, intr_s, ovr_s, inte_s;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    ppi_mode1_handshake dut (
        .CLK       (clk_s),
        .RESET_N   (rst_n_s),
        .MODE1_EN  (mode1_en_s),
        .DIR_IN    (dir_in_s),
        .SEL       (sel_s),
        .READ      (read_s),
        .WRITE     (write_s),
        .DATA_W    (data_w_s),
        .PORT_PINS (port_pins_s),
        .STB_N     (stb_n_s),
        .ACK_N     (ack_n_s),
        .INTE_SET  (inte_set_s),
        .INTE_CLR  (inte_clr_s),
        .DATA_R    (data_r_s),
        .PORT_OUT  (port_out_s),
        .PORT_OE   (port_oe_s),
        .IBF       (ibf_s),
        .OBF_N     (obf_n_s),
        .INTR      (intr_s),
        .OVR       (ovr_s),
        .INTE      (inte_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_s);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_data_r"},   32'(data_r_s),   32'h00);
        check_value({tag, "_port_out"}, 32'(port_out_s), 32'h00);
        check_value({tag, "_port_oe"},  32'(port_oe_s),  32'h0);
        check_value({tag, "_ibf"},      32'(ibf_s),      32'h0);
        check_value({tag, "_obf_n"},    32'(obf_n_s),    32'h1);
        check_value({tag, "_intr"},     32'(intr_s),     32'h0);
        check_value({tag, "_ovr"},      32'(ovr_s),      32'h0);
        check_value({tag, "_inte"},     32'(inte_s),     32'h0);
    endtask

    task automatic cpu_write(input logic [7:0] d, input logic [7:0] exp_out);
        data_w_s = d; sel_s = 1'b1; write_s = 1'b1;
        tick(1);
        check_value("wr_port_out", 32'(port_out_s), 32'(exp_out));
        write_s = 1'b0;
        tick(1);
        check_value("wr_obf_n", 32'(obf_n_s), 32'h0);
        sel_s = 1'b0;
    endtask

    initial begin
        rst_n_s = 1'b0; mode1_en_s = 1'b1; dir_in_s = 1'b1; sel_s = 1'b0;
        read_s = 1'b0; write_s = 1'b0; data_w_s = 8'h00; port_pins_s = 8'h00;
        stb_n_s = 1'b1; ack_n_s = 1'b1; inte_set_s = 1'b0; inte_clr_s = 1'b0;
        #12;
        check_reset_values("rst");
        @(posedge clk_s); #1;
        rst_n_s = 1'b1;
        tick(2);

        // Enable interrupts
        inte_set_s = 1'b1; tick(1); inte_set_s = 1'b0;
        check_value("inte_set", 32'(inte_s), 32'h1);

        // Input handshake with latency check
        port_pins_s = 8'h9B; stb_n_s = 1'b0;
        tick(LAT);
        check_value("lat_ibf_early", 32'(ibf_s), 32'h0);
        tick(1);
        check_value("lat_ibf_on", 32'(ibf_s), 32'h1);
        check_value("in_data_r", 32'(data_r_s), 32'h9B);
        tick(4 - (LAT + 1));
        port_pins_s = 8'h00;
        check_value("in_intr_pre", 32'(intr_s), 32'h0);
        stb_n_s = 1'b1;
        tick(LAT + 1);
        check_value("in_intr_rise", 32'(intr_s), 32'h1);
        sel_s = 1'b1; read_s = 1'b1; tick(1);
        check_value("rd_as_intr", 32'(intr_s), 32'h0);
        check_value("rd_as_ibf", 32'(ibf_s), 32'h1);
        read_s = 1'b0; tick(1);
        check_value("rd_de_ibf", 32'(ibf_s), 32'h0);
        sel_s = 1'b0;

        // Overrun
        port_pins_s = 8'h9B; stb_n_s = 1'b0; tick(3);
        stb_n_s = 1'b1; tick(3);
        port_pins_s = 8'h11; stb_n_s = 1'b0; tick(LAT + 1);
        check_value("ovr_data_r", 32'(data_r_s), 32'h9B);
        check_value("ovr_set", 32'(ovr_s), 32'h1);
        tick(2); stb_n_s = 1'b1; tick(3);
        check_value("ovr_sticky", 32'(ovr_s), 32'h1);
        sel_s = 1'b1; read_s = 1'b1; tick(1);
        read_s = 1'b0; tick(1);
        check_value("ovr_clr", 32'(ovr_s), 32'h0);
        check_value("ovr_ibf_clr", 32'(ibf_s), 32'h0);
        sel_s = 1'b0;

        // Switch to output mode; ACK_N in OUT_EMPTY is ignored
        dir_in_s = 1'b0; tick(2);
        check_value("out_oe", 32'(port_oe_s), 32'h1);
        check_value("out_obf_n", 32'(obf_n_s), 32'h1);
        ack_n_s = 1'b0; tick(3); ack_n_s = 1'b1; tick(3);
        check_value("ack_empty_intr", 32'(intr_s), 32'h0);
        check_value("ack_empty_obf", 32'(obf_n_s), 32'h1);

        // Output handshake, including overwrite while full
        cpu_write(8'hFF, 8'hFF);
        cpu_write(8'h3C, 8'h3C);
        ack_n_s = 1'b0; tick(LAT + 1);
        check_value("ack_fall_obf", 32'(obf_n_s), 32'h1);
        check_value("ack_fall_intr", 32'(intr_s), 32'h0);
        tick(2); ack_n_s = 1'b1; tick(LAT);
        check_value("ack_rise_early", 32'(intr_s), 32'h0);
        tick(1);
        check_value("ack_rise_intr", 32'(intr_s), 32'h1);

        // Interrupt disabled handshake
        inte_clr_s = 1'b1; tick(1); inte_clr_s = 1'b0;
        check_value("inte_clr", 32'(inte_s), 32'h0);
        check_value("inte_clr_intr", 32'(intr_s), 32'h0);
        cpu_write(8'h5A, 8'h5A);
        ack_n_s = 1'b0; tick(3); ack_n_s = 1'b1; tick(3);
        check_value("noint_intr", 32'(intr_s), 32'h0);
        check_value("noint_obf", 32'(obf_n_s), 32'h1);

        // Simultaneous set and clear, then re-enable with pending request
        inte_set_s = 1'b1; inte_clr_s = 1'b1; tick(1);
        inte_set_s = 1'b0; inte_clr_s = 1'b0;
        check_value("inte_both", 32'(inte_s), 32'h0);
        inte_set_s = 1'b1; tick(1); inte_set_s = 1'b0;
        check_value("inte_reen_intr", 32'(intr_s), 32'h1);

        // Reset in the middle of an input handshake
        dir_in_s = 1'b1; tick(2);
        check_value("cfg_intr_clr", 32'(intr_s), 32'h0);
        check_value("cfg_oe_off", 32'(port_oe_s), 32'h0);
        port_pins_s = 8'hA5; stb_n_s = 1'b0; tick(3);
        stb_n_s = 1'b1; tick(LAT + 1);
        check_value("mid_ibf", 32'(ibf_s), 32'h1);
        check_value("mid_intr", 32'(intr_s), 32'h1);
        #2;
        rst_n_s = 1'b0;
        #1;
        check_reset_values("async_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
